seq_pattern_generator: RTL

Serial test-pattern transmitter. It produces the single-bit stream (x) that feeds the codebase's serial sequence detectors, such as seq_detector_1010.
A start pulse loads a pattern of up to PAT_W bits, a length, a repeat count and an inter-copy gap. The block then shifts the pattern out MSB-first, one bit per clk, for the requested number of copies.
It is used as on-chip stimulus and in loopback benches of the detector blocks.

---
 rtl/seq_pattern_generator.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/seq_pattern_generator.sv
// Serial test-pattern transmitter: shifts a captured pattern out MSB-first.
// Optional SEQGEN_ERR_INJECT_EN adds single-bit corruption of the first copy.
module seq_pattern_generator #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 4,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic [REP_W-1:0] rep,
  input  logic [GAP_W-1:0] gap,
`ifdef SEQGEN_ERR_INJECT_EN
  input  logic             err_inject,
  input  logic [LEN_W-1:0] err_pos,
`endif
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  state_t           state, state_n;
  logic [PAT_W-1:0] pat_q, pat_n;
  logic [LEN_W-1:0] lm1_q, lm1_n, lm1_cap;
  logic [GAP_W-1:0] gap_q, gap_n;
  logic             cont_q, cont_n;
  logic [LEN_W-1:0] bcnt, bcnt_n;
  logic [REP_W-1:0] rcnt, rcnt_n;
  logic [GAP_W-1:0] gcnt, gcnt_n;
  logic             first_q, first_n;
  logic             emit, adv, flip;
  logic             x_n, busy_n, done_n, aborted_n;

  function automatic logic bit_at(
    input logic [PAT_W-1:0] p,
    input logic [LEN_W-1:0] i
  );
    logic [PAT_W-1:0] t;
    t = p >> i;
    return t[0];
  endfunction

  always_comb begin
    lm1_cap = pat_len - 1'b1;
    if (pat_len == '0)
      lm1_cap = '0;
    else if (pat_len > LEN_W'(PAT_W))
      lm1_cap = LEN_W'(PAT_W - 1);
  end

  // Registers hold what is on x this cycle; bcnt is the bit index shown.
  always_comb begin
    state_n   = state;
    pat_n     = pat_q;
    lm1_n     = lm1_q;
    gap_n     = gap_q;
    cont_n    = cont_q;
    bcnt_n    = bcnt;
    rcnt_n    = rcnt;
    gcnt_n    = gcnt;
    first_n   = first_q;
    emit      = 1'b0;
    adv       = 1'b0;
    busy_n    = 1'b0;
    done_n    = 1'b0;
    aborted_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = SHIFT;
          pat_n   = pattern;
          lm1_n   = lm1_cap;
          gap_n   = gap;
          cont_n  = (rep == '0);
          rcnt_n  = (rep == '0) ? '0 : rep - 1'b1;
          bcnt_n  = lm1_cap;
          gcnt_n  = '0;
          first_n = 1'b1;
          emit    = 1'b1;
          busy_n  = 1'b1;
        end
      end
      SHIFT: begin
        if (stop) begin
          state_n   = IDLE;
          aborted_n = 1'b1;
        end else if (bcnt != '0) begin
          bcnt_n = bcnt - 1'b1;
          emit   = 1'b1;
          busy_n = 1'b1;
        end else if (!cont_q && rcnt == '0) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else if (gap_q != '0) begin
          state_n = GAP;
          gcnt_n  = gap_q - 1'b1;
          first_n = 1'b0;
          busy_n  = 1'b1;
        end else begin
          adv = 1'b1;
        end
      end
      GAP: begin
        if (stop) begin
          state_n   = IDLE;
          aborted_n = 1'b1;
        end else if (gcnt != '0) begin
          gcnt_n = gcnt - 1'b1;
          busy_n = 1'b1;
        end else begin
          adv = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // A copy only starts when copies remain, so rcnt never wraps.
    if (adv) begin
      state_n = SHIFT;
      bcnt_n  = lm1_q;
      first_n = 1'b0;
      emit    = 1'b1;
      busy_n  = 1'b1;
      if (!cont_q)
        rcnt_n = rcnt - 1'b1;
    end
  end

`ifdef SEQGEN_ERR_INJECT_EN
  logic             inj_q, inj_n;
  logic [LEN_W-1:0] epos_q, epos_n;

  always_comb begin
    inj_n  = inj_q;
    epos_n = epos_q;
    if (state == IDLE && start) begin
      inj_n  = err_inject;
      epos_n = err_pos;
    end
    flip = inj_n & first_n & (bcnt_n == epos_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_q  <= 1'b0;
      epos_q <= '0;
    end else begin
      inj_q  <= inj_n;
      epos_q <= epos_n;
    end
  end
`else
  assign flip = 1'b0;
`endif

  assign x_n = emit & (bit_at(pat_n, bcnt_n) ^ flip);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pat_q   <= '0;
      lm1_q   <= '0;
      gap_q   <= '0;
      cont_q  <= 1'b0;
      bcnt    <= '0;
      rcnt    <= '0;
      gcnt    <= '0;
      first_q <= 1'b0;
      x       <= 1'b0;
      x_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      state   <= state_n;
      pat_q   <= pat_n;
      lm1_q   <= lm1_n;
      gap_q   <= gap_n;
      cont_q  <= cont_n;
      bcnt    <= bcnt_n;
      rcnt    <= rcnt_n;
      gcnt    <= gcnt_n;
      first_q <= first_n;
      x       <= x_n;
      x_valid <= emit;
      busy    <= busy_n;
      done    <= done_n;
      aborted <= aborted_n;
    end
  end

endmodule
